seqdivider: RTL and testbench
=============================

# seqdivider

Sequential restoring unsigned divider: the inverse of the team's combinational array multiplier. It accepts an n-bit dividend and an n-bit divisor, resolves one quotient bit per clock, and returns an n-bit quotient and an n-bit remainder. It sits beside the multiplier in the D1 arithmetic datapath and uses a start/busy/done handshake, so a controller can issue divisions back-to-back.

## Interface
- `n`, default 4: operand, quotient and remainder width in bits; n ≥ 2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only when not busy.
- `A`  in  n  dividend (unsigned); sampled with `start`.
- `B`  in  n  divisor (unsigned); sampled with `start`.
- `Q`  out  n  quotient; registered.
- `R`  out  n  remainder; registered.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; `Q` and `R` are valid from this cycle onward.
- `divzero`  out  1  set with `done` when `B` was 0; holds until the next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - `rem` (n+1 bits): partial remainder.
  - `quo` (n bits): holds the dividend, shifted out MSB-first as quotient bits shift in.
  - `div` (n bits): divisor.
  - `cnt` (ceil(log2 n) bits): step counter.
- IDLE or DONE with `start`=1:
  - Latch `quo`←A, `div`←B, `rem`←0, `cnt`←n−1; clear `divzero`.
  - If B≠0, go to RUN.
  - If B=0, go to DONE with `Q`←all ones, `R`←A, `divzero`←1.
- IDLE or DONE with `start`=0: DONE goes to IDLE. `Q`, `R` and `divzero` hold.
- RUN step (one per clock):
  - t = {rem[n−1:0], quo[n−1]}.
  - If t ≥ {0,div}: rem←t−div and shift 1 into the quo LSB.
  - Otherwise: rem←t and shift 0 into the quo LSB.
  - Decrement `cnt`.
  - On the step where `cnt`=0, also write `Q`←new quo, `R`←new rem[n−1:0], and go to DONE.
- `busy` = (state==RUN). `done` = (state==DONE).
- `start` while in RUN is ignored. No queuing; A and B may change freely while busy.
- Arithmetic: the quotient fits in n bits and the remainder is always < B. The extra bit of `rem` only holds the compare carry.

## Timing
- Reset: state IDLE; `Q`=0, `R`=0, `busy`=0, `done`=0, `divzero`=0. Internal registers cleared.
- Reset has priority over everything, including mid-RUN. The in-flight division is discarded and no `done` pulse is produced.
- Normal latency, with `start` sampled at edge t:
  - `busy` is high after edges t … t+n−1.
  - `done` is high for exactly the cycle after edge t+n.
  - Total: n+1 cycles from the start edge to the `done` cycle.
- Divide-by-zero latency: `done` and `divzero` go high in the cycle after edge t. `busy` never rises.
- Back-to-back: `start` high during the DONE cycle is accepted, so `done` is a single-cycle pulse even under continuous `start`. Sustained throughput is one result every n+1 cycles.
- `Q` and `R` change only at the final RUN step or on a divide-by-zero load. They are stable between `done` pulses.
- With `start` held high from IDLE, the next division begins immediately after DONE.

## Test plan
- n=4, A=13, B=4, single `start` pulse:
  - `busy` is high for 4 cycles.
  - `done` pulses in the 5th cycle with Q=3, R=1, `divzero`=0.
- n=4, A=7, B=0:
  - `done`=1 and `divzero`=1 one cycle after `start`, with Q=15, R=7, `busy` never high.
  - Then A=15, B=1 gives Q=15, R=0, and `divzero` clears at that `start`.
- n=4, A=3, B=9:
  - Q=0, R=3.
  - Pulsing `start` with A=1, B=1 during RUN must not disturb the result or the timing.
- Reset mid-RUN (after 2 steps of A=14, B=3):
  - All outputs are 0 the next cycle and no `done` follows.
  - A new `start` with A=14, B=3 then yields Q=4, R=2 after the normal latency.
- `start` held high continuously: `done` pulses every 5 cycles (n=4) and each result matches the operands sampled at its start edge.
- Exhaustive run for n=4 (all 256 A/B pairs) and a random run for n=8:
  - For B≠0: check Q*B+R==A and R<B.
  - For B=0: check `divzero`=1, Q=all ones, R=A.

Source files
------------

// File: rtl/seqdivider.sv
// seqdivider -- sequential restoring unsigned divider.
//
// Resolves one quotient bit per clock using a restoring shift/subtract
// loop. A start/busy/done handshake lets a controller issue divisions
// back-to-back: a start seen in the DONE cycle is accepted immediately.
//
// Ports:
//   clock    in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   start    in   1  request a division (ignored while busy)
//   A        in   n  dividend, sampled with start
//   B        in   n  divisor, sampled with start
//   Q        out  n  quotient (registered)
//   R        out  n  remainder (registered)
//   busy     out  1  division in progress
//   done     out  1  one-cycle pulse, Q/R valid from this cycle onward
//   divzero  out  1  last accepted division had B == 0
module seqdivider #(
  parameter int n = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         divzero
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [n:0]     rem_q, rem_d;
  logic [n-1:0]   quo_q, quo_d;
  logic [n-1:0]   div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [n-1:0]   qOut_q, qOut_d;
  logic [n-1:0]   rOut_q, rOut_d;
  logic           divzero_q, divzero_d;

  logic [n:0]     trial;
  logic [n:0]     diff;
  logic           fits;
  logic [n:0]     remNext;
  logic [n-1:0]   quoNext;

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      qOut_q    <= '0;
      rOut_q    <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      qOut_q    <= qOut_d;
      rOut_q    <= rOut_d;
      divzero_q <= divzero_d;
    end
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits. The remainder always
  // stays below the divisor, so its top bit only ever carries the shifted
  // out compare bit and is dropped by the shift.
  always_comb begin
    trial   = (rem_q << 1) | (n + 1)'(quo_q[n-1]);
    diff    = trial - {1'b0, div_q};
    fits    = (trial >= {1'b0, div_q});
    remNext = fits ? diff : trial;
    quoNext = {quo_q[n-2:0], fits};
  end

  // Next-state and register updates; everything holds by default.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    qOut_d    = qOut_q;
    rOut_d    = rOut_q;
    divzero_d = divzero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          quo_d     = A;
          div_d     = B;
          rem_d     = '0;
          cnt_d     = CNT_LAST;
          divzero_d = 1'b0;
          if (B != '0) begin
            state_d = RUN;
          end else begin
            // Divide by zero skips the loop and reports a saturated quotient.
            state_d   = DONE;
            qOut_d    = '1;
            rOut_d    = A;
            divzero_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        rem_d = remNext;
        quo_d = quoNext;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          qOut_d  = quoNext;
          rOut_d  = remNext[n-1:0];
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Q       = qOut_q;
  assign R       = rOut_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign divzero = divzero_q;

endmodule

// File: tb/tb_seqdivider.sv
// tb_seqdivider -- self-checking bench for seqdivider (n=4 and n=8).
module tb_seqdivider;

  logic       clock;
  logic       reset;

  logic       start4;
  logic [3:0] a4, b4, q4, r4;
  logic       busy4, done4, dz4;

  logic       start8;
  logic [7:0] a8, b8, q8, r8;
  logic       busy8, done8, dz8;

  int assertCount = 0;
  int failCount   = 0;

  seqdivider #(.n(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .A(a4), .B(b4),
    .Q(q4), .R(r4), .busy(busy4), .done(done4), .divzero(dz4)
  );

  seqdivider #(.n(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .A(a8), .B(b8),
    .Q(q8), .R(r8), .busy(busy8), .done(done8), .divzero(dz8)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
    int         busyN;
  } vec_t;

  vec_t vecs[10];

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one division on the n=4 unit and wait (bounded) for done.
  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic dz, output int lat, output int busyN);
    @(negedge clock);
    start4 = 1'b1; a4 = a; b4 = b;
    @(negedge clock);
    start4 = 1'b0;
    lat = 1; busyN = 0;
    while (!done4 && lat < 30) begin
      if (busy4) busyN++;
      @(negedge clock);
      lat++;
    end
    q = q4; r = r4; dz = dz4;
    checkOutput("busyAtDone4", int'(busy4), 0);
    @(negedge clock);
    checkOutput("donePulseWidth4", int'(done4), 0);
  endtask

  // Same for the n=8 unit.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output int lat);
    @(negedge clock);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clock);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    q = q8; r = r8; dz = dz8;
  endtask

  logic [3:0] q, r;
  logic       dz;
  logic [7:0] q8v, r8v;
  logic       dz8v;
  int         lat, busyN, cyc, doneSeen, busySeen;
  logic [3:0] contA[4], contB[4], contQ[4], contR[4];

  initial begin
    vecs[0] = '{a:4'd13, b:4'd4,  q:4'd3,  r:4'd1, dz:1'b0, lat:5, busyN:4};
    vecs[1] = '{a:4'd7,  b:4'd0,  q:4'd15, r:4'd7, dz:1'b1, lat:1, busyN:0};
    vecs[2] = '{a:4'd15, b:4'd1,  q:4'd15, r:4'd0, dz:1'b0, lat:5, busyN:4};
    vecs[3] = '{a:4'd3,  b:4'd9,  q:4'd0,  r:4'd3, dz:1'b0, lat:5, busyN:4};
    vecs[4] = '{a:4'd14, b:4'd3,  q:4'd4,  r:4'd2, dz:1'b0, lat:5, busyN:4};
    vecs[5] = '{a:4'd15, b:4'd15, q:4'd1,  r:4'd0, dz:1'b0, lat:5, busyN:4};
    vecs[6] = '{a:4'd0,  b:4'd5,  q:4'd0,  r:4'd0, dz:1'b0, lat:5, busyN:4};
    vecs[7] = '{a:4'd9,  b:4'd2,  q:4'd4,  r:4'd1, dz:1'b0, lat:5, busyN:4};
    vecs[8] = '{a:4'd15, b:4'd7,  q:4'd2,  r:4'd1, dz:1'b0, lat:5, busyN:4};
    vecs[9] = '{a:4'd1,  b:4'd15, q:4'd0,  r:4'd1, dz:1'b0, lat:5, busyN:4};

    contA = '{4'd13, 4'd14, 4'd9, 4'd15};
    contB = '{4'd4,  4'd3,  4'd2, 4'd7};
    contQ = '{4'd3,  4'd4,  4'd4, 4'd2};
    contR = '{4'd1,  4'd2,  4'd1, 4'd1};

    reset = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clock);

    // Reset state of both units.
    checkOutput("resetQ4", int'(q4), 0);
    checkOutput("resetR4", int'(r4), 0);
    checkOutput("resetBusy4", int'(busy4), 0);
    checkOutput("resetDone4", int'(done4), 0);
    checkOutput("resetDivzero4", int'(dz4), 0);
    checkOutput("resetQ8", int'(q8), 0);
    checkOutput("resetDone8", int'(done8), 0);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus4(vecs[i].a, vecs[i].b, q, r, dz, lat, busyN);
      checkOutput($sformatf("vec%0d.Q", i), int'(q), int'(vecs[i].q));
      checkOutput($sformatf("vec%0d.R", i), int'(r), int'(vecs[i].r));
      checkOutput($sformatf("vec%0d.divzero", i), int'(dz), int'(vecs[i].dz));
      checkOutput($sformatf("vec%0d.latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d.busyCycles", i), busyN, vecs[i].busyN);
    end

    // divzero, Q and R hold after returning to IDLE.
    applyStimulus4(4'd7, 4'd0, q, r, dz, lat, busyN);
    repeat (3) @(negedge clock);
    checkOutput("holdDivzero", int'(dz4), 1);
    checkOutput("holdQ", int'(q4), 15);
    checkOutput("holdR", int'(r4), 7);
    checkOutput("holdDone", int'(done4), 0);

    // start pulsed during RUN is ignored.
    @(negedge clock);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd9;
    @(negedge clock);
    start4 = 1'b0; lat = 1;
    @(negedge clock);
    lat = 2;
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clock);
    lat = 3;
    start4 = 1'b0;
    while (!done4 && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("ignoreStart.latency", lat, 5);
    checkOutput("ignoreStart.Q", int'(q4), 0);
    checkOutput("ignoreStart.R", int'(r4), 3);
    doneSeen = 0; busySeen = 0;
    repeat (8) begin
      @(negedge clock);
      if (done4) doneSeen++;
      if (busy4) busySeen++;
    end
    checkOutput("ignoreStart.extraDone", doneSeen, 0);
    checkOutput("ignoreStart.extraBusy", busySeen, 0);

    // start held high: a result every 5 cycles, each from its own operands.
    @(negedge clock);
    start4 = 1'b1; a4 = contA[0]; b4 = contB[0];
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do begin
        @(negedge clock);
        cyc++;
      end while (!done4 && cyc < 30);
      checkOutput($sformatf("cont%0d.period", k), cyc, 5);
      checkOutput($sformatf("cont%0d.Q", k), int'(q4), int'(contQ[k]));
      checkOutput($sformatf("cont%0d.R", k), int'(r4), int'(contR[k]));
      if (k < 3) begin
        a4 = contA[k+1]; b4 = contB[k+1];
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clock);
    checkOutput("cont.doneAfterStop", int'(done4), 0);
    checkOutput("cont.busyAfterStop", int'(busy4), 0);

    // Reset after two RUN steps discards the division.
    @(negedge clock);
    start4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
    @(negedge clock);
    start4 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midReset.Q", int'(q4), 0);
    checkOutput("midReset.R", int'(r4), 0);
    checkOutput("midReset.busy", int'(busy4), 0);
    checkOutput("midReset.done", int'(done4), 0);
    checkOutput("midReset.divzero", int'(dz4), 0);
    reset = 1'b0;
    doneSeen = 0;
    repeat (8) begin
      @(negedge clock);
      if (done4 || busy4) doneSeen++;
    end
    checkOutput("midReset.noDone", doneSeen, 0);
    applyStimulus4(4'd14, 4'd3, q, r, dz, lat, busyN);
    checkOutput("afterReset.Q", int'(q), 4);
    checkOutput("afterReset.R", int'(r), 2);
    checkOutput("afterReset.latency", lat, 5);

    // Exhaustive n=4.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        applyStimulus4(4'(ia), 4'(ib), q, r, dz, lat, busyN);
        if (ib != 0) begin
          checkOutput($sformatf("ex %0d/%0d QB+R", ia, ib), int'(q) * ib + int'(r), ia);
          checkOutput($sformatf("ex %0d/%0d R<B", ia, ib), int'(int'(r) < ib), 1);
          checkOutput($sformatf("ex %0d/%0d Q", ia, ib), int'(q), ia / ib);
          checkOutput($sformatf("ex %0d/%0d divzero", ia, ib), int'(dz), 0);
          checkOutput($sformatf("ex %0d/%0d latency", ia, ib), lat, 5);
        end else begin
          checkOutput($sformatf("ex %0d/0 divzero", ia), int'(dz), 1);
          checkOutput($sformatf("ex %0d/0 Q", ia), int'(q), 15);
          checkOutput($sformatf("ex %0d/0 R", ia), int'(r), ia);
          checkOutput($sformatf("ex %0d/0 latency", ia), lat, 1);
        end
      end
    end

    // Random n=8, every eighth divisor forced to zero.
    for (int i = 0; i < 200; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? 0 : int'($urandom_range(0, 255));
      applyStimulus8(8'(ra), 8'(rb), q8v, r8v, dz8v, lat);
      if (rb != 0) begin
        checkOutput($sformatf("rnd %0d/%0d QB+R", ra, rb), int'(q8v) * rb + int'(r8v), ra);
        checkOutput($sformatf("rnd %0d/%0d R<B", ra, rb), int'(int'(r8v) < rb), 1);
        checkOutput($sformatf("rnd %0d/%0d latency", ra, rb), lat, 9);
      end else begin
        checkOutput($sformatf("rnd %0d/0 divzero", ra), int'(dz8v), 1);
        checkOutput($sformatf("rnd %0d/0 Q", ra), int'(q8v), 255);
        checkOutput($sformatf("rnd %0d/0 R", ra), int'(r8v), ra);
        checkOutput($sformatf("rnd %0d/0 latency", ra), lat, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
